// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: screen geometry and the pixel word that
// travels between the renderers, the clip FIFO and the adapter.
package vga_pkg;

   localparam int unsigned SCREEN_W = 160;
   localparam int unsigned SCREEN_H = 120;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] colour;
   } pixel_t;

   // Statistics counters stick at all-ones rather than wrapping back to zero.
   function automatic logic [15:0] sat_inc16(input logic [15:0] val);
      logic [15:0] res;
      if (val == 16'hFFFF) begin
         res = val;
      end else begin
         res = val + 16'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/plot_fifo_mem.sv
// Pixel storage for the clip FIFO: register array with a synchronous write
// port and an asynchronous read port.
module plot_fifo_mem
   import vga_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  pixel_t        wdata_i,
   input  logic [AW-1:0] raddr_i,
   output pixel_t        rdata_o
);

   pixel_t mem_q [DEPTH];

   // Write port; contents need no reset because the reader gates on occupancy.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/plot_clip_fifo.sv
// Clip-and-buffer stage between the shape renderers and the VGA adapter:
// drops off-screen pixels, queues on-screen ones and keeps drop statistics.
module plot_clip_fifo
   import vga_pkg::*;
#(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned SCREEN_W = vga_pkg::SCREEN_W,
   parameter int unsigned SCREEN_H = vga_pkg::SCREEN_H,
   parameter int unsigned CW       = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    in_x,
   input  logic [6:0]    in_y,
   input  logic [2:0]    in_colour,
   input  logic          in_plot,
   output logic [7:0]    out_x,
   output logic [6:0]    out_y,
   output logic [2:0]    out_colour,
   output logic          out_plot,
   input  logic          out_ready,
   output logic [CW-1:0] count,
   output logic          overflow,
   output logic [15:0]   clipped_cnt,
   input  logic          clear_stats
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [15:0]   clipped_q, clipped_d;

   logic   in_range_s;
   logic   empty_s;
   logic   full_s;
   logic   pop_s;
   logic   push_s;
   pixel_t wdata_s;
   pixel_t rdata_s;

   // Full-width unsigned compare so x=160..255 and y=120..127 are all rejected.
   assign in_range_s = ({24'd0, in_x} < SCREEN_W) && ({25'd0, in_y} < SCREEN_H);
   assign empty_s    = (count_q == {CW{1'b0}});
   assign full_s     = (count_q == FULL_CNT);
   assign pop_s      = !empty_s && out_ready;
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign push_s     = in_plot && in_range_s && (!full_s || pop_s);

   assign wdata_s.x      = in_x;
   assign wdata_s.y      = in_y;
   assign wdata_s.colour = in_colour;

   plot_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .we_i    (push_s),
      .waddr_i (wr_ptr_q),
      .wdata_i (wdata_s),
      .raddr_i (rd_ptr_q),
      .rdata_o (rdata_s)
   );

   // Pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Statistics next-state: a drop in the same cycle overrides clear_stats.
   always_comb begin
      overflow_d = overflow_q;
      clipped_d  = clipped_q;
      if (in_plot && in_range_s && !push_s) begin
         overflow_d = 1'b1;
      end else if (clear_stats) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
      if (in_plot && !in_range_s) begin
         if (clear_stats) begin
            clipped_d = 16'd1;
         end else begin
            clipped_d = sat_inc16(clipped_q);
         end
      end else if (clear_stats) begin
         clipped_d = 16'd0;
      end else begin
         clipped_d = clipped_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= {AW{1'b0}};
         rd_ptr_q   <= {AW{1'b0}};
         count_q    <= {CW{1'b0}};
         overflow_q <= 1'b0;
         clipped_q  <= 16'd0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         clipped_q  <= clipped_d;
      end
   end

   // Head of queue, forced to zero while empty so stale storage never leaks out.
   always_comb begin
      out_x      = 8'd0;
      out_y      = 7'd0;
      out_colour = 3'd0;
      if (!empty_s) begin
         out_x      = rdata_s.x;
         out_y      = rdata_s.y;
         out_colour = rdata_s.colour;
      end else begin
         out_x      = 8'd0;
         out_y      = 7'd0;
         out_colour = 3'd0;
      end
   end

   assign out_plot    = !empty_s;
   assign count       = count_q;
   assign overflow    = overflow_q;
   assign clipped_cnt = clipped_q;

endmodule

// File: tb/tb_plot_clip_fifo.sv
// Bench for plot_clip_fifo: directed scenarios plus randomized traffic checked
// every cycle against a queue-based reference model.
module tb_plot_clip_fifo;
   import vga_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [7:0]  in_x;
   logic [6:0]  in_y;
   logic [2:0]  in_colour;
   logic        in_plot;
   logic [7:0]  out_x;
   logic [6:0]  out_y;
   logic [2:0]  out_colour;
   logic        out_plot;
   logic        out_ready;
   logic [4:0]  count;
   logic        overflow;
   logic [15:0] clipped_cnt;
   logic        clear_stats;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // reference model state
   logic [17:0] mq[$];
   int          m_clip;
   bit          m_ovf;
   logic [17:0] out_log[$];

   plot_clip_fifo dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_x        (in_x),
      .in_y        (in_y),
      .in_colour   (in_colour),
      .in_plot     (in_plot),
      .out_x       (out_x),
      .out_y       (out_y),
      .out_colour  (out_colour),
      .out_plot    (out_plot),
      .out_ready   (out_ready),
      .count       (count),
      .overflow    (overflow),
      .clipped_cnt (clipped_cnt),
      .clear_stats (clear_stats)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model one clock edge from the pixel-stream rules, using the inputs sampled at that edge.
   task automatic model_edge();
      bit pop, inr;
      if (!rst_n) begin
         mq.delete();
         m_clip = 0;
         m_ovf  = 1'b0;
      end else begin
         pop = (mq.size() > 0) && out_ready;
         inr = (int'(in_x) < 160) && (int'(in_y) < 120);
         if (clear_stats) begin
            m_clip = 0;
            m_ovf  = 1'b0;
         end
         if (in_plot && inr) begin
            if (mq.size() < 16 || pop) begin
               if (pop) void'(mq.pop_front());
               pop = 1'b0;
               mq.push_back({in_x, in_y, in_colour});
            end else begin
               m_ovf = 1'b1;
            end
         end
         if (in_plot && !inr && m_clip < 65535) m_clip++;
         if (pop) void'(mq.pop_front());
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input int x, input int y, input int c, input bit p);
      in_x      = 8'(x);
      in_y      = 7'(y);
      in_colour = 3'(c);
      in_plot   = p;
   endtask

   // Per-cycle comparison against the model, plus a log of every accepted pop.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_plot", {31'd0, out_plot}, {31'd0, mq.size() != 0});
         chk("count", {27'd0, count}, mq.size());
         chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
         chk("clipped_cnt", {16'd0, clipped_cnt}, m_clip);
         if (mq.size() != 0)
            chk("out_pixel", {14'd0, out_x, out_y, out_colour}, {14'd0, mq[0]});
         else
            chk("out_pixel_zero", {14'd0, out_x, out_y, out_colour}, 32'd0);
         if (out_plot && out_ready) out_log.push_back({out_x, out_y, out_colour});
      end
   end

   initial begin
      rst_n = 1'b0; out_ready = 1'b0; clear_stats = 1'b0;
      drive(0, 0, 0, 1'b0);
      tick(); tick();
      chk_en = 1'b1;
      rst_n  = 1'b1;
      tick();
      chk("rst_count", {27'd0, count}, 32'd0);
      chk("rst_out_plot", {31'd0, out_plot}, 32'd0);
      chk("rst_clip", {16'd0, clipped_cnt}, 32'd0);

      // 1: three pixels, streaming out
      out_ready = 1'b1;
      out_log.delete();
      drive(10, 20, 1, 1'b1);
      chk("t1_pre_plot", {31'd0, out_plot}, 32'd0);
      tick();
      chk("t1_plot_c2", {31'd0, out_plot}, 32'd1);
      chk("t1_x_c2", {24'd0, out_x}, 32'd10);
      drive(11, 20, 2, 1'b1); tick();
      drive(12, 20, 3, 1'b1); tick();
      drive(0, 0, 0, 1'b0);
      repeat (3) tick();
      chk("t1_count", {27'd0, count}, 32'd0);
      chk("t1_ovf", {31'd0, overflow}, 32'd0);
      chk("t1_nlog", out_log.size(), 32'd3);
      if (out_log.size() == 3) begin
         chk("t1_p0", {14'd0, out_log[0]}, {14'd0, 8'd10, 7'd20, 3'd1});
         chk("t1_p1", {14'd0, out_log[1]}, {14'd0, 8'd11, 7'd20, 3'd2});
         chk("t1_p2", {14'd0, out_log[2]}, {14'd0, 8'd12, 7'd20, 3'd3});
      end

      // 2: clipping boundaries
      out_log.delete();
      drive(160, 5, 4, 1'b1); tick();
      drive(5, 120, 4, 1'b1); tick();
      drive(255, 127, 4, 1'b1); tick();
      drive(159, 119, 6, 1'b1); tick();
      drive(0, 0, 0, 1'b0);
      repeat (3) tick();
      chk("t2_clip", {16'd0, clipped_cnt}, 32'd3);
      chk("t2_nlog", out_log.size(), 32'd1);
      if (out_log.size() == 1)
         chk("t2_p", {14'd0, out_log[0]}, {14'd0, 8'd159, 7'd119, 3'd6});

      // 3: fill past capacity
      out_ready = 1'b0;
      out_log.delete();
      for (int i = 1; i <= 17; i++) begin
         drive(i, i, i, 1'b1); tick();
      end
      drive(0, 0, 0, 1'b0);
      chk("t3_count", {27'd0, count}, 32'd16);
      chk("t3_ovf", {31'd0, overflow}, 32'd1);
      out_ready = 1'b1;
      repeat (20) tick();
      chk("t3_nlog", out_log.size(), 32'd16);
      for (int i = 0; i < out_log.size() && i < 16; i++)
         chk("t3_order", {24'd0, out_log[i][17:10]}, i + 1);

      // 4: full with simultaneous push and pop
      clear_stats = 1'b1; tick(); clear_stats = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         drive(50 + i, 3, 2, 1'b1); tick();
      end
      chk("t4_full", {27'd0, count}, 32'd16);
      out_ready = 1'b1;
      drive(99, 4, 5, 1'b1); tick();
      drive(0, 0, 0, 1'b0);
      chk("t4_count", {27'd0, count}, 32'd16);
      chk("t4_ovf", {31'd0, overflow}, 32'd0);
      chk("t4_head", {24'd0, out_x}, 32'd51);
      repeat (20) tick();

      // 5: stall stability
      out_ready = 1'b0;
      drive(70, 1, 5, 1'b1); tick();
      drive(71, 2, 6, 1'b1); tick();
      drive(0, 0, 0, 1'b0);
      tick();
      chk("t5_a", {24'd0, out_x}, 32'd70);
      out_ready = 1'b0; tick(); chk("t5_b", {24'd0, out_x}, 32'd70);
      out_ready = 1'b1; tick(); chk("t5_c", {24'd0, out_x}, 32'd71);
      out_ready = 1'b0; tick(); chk("t5_d", {24'd0, out_x}, 32'd71);
      out_ready = 1'b1; tick(); chk("t5_e", {31'd0, out_plot}, 32'd0);

      // 6: clear vs clip, then reset with data queued
      clear_stats = 1'b1;
      drive(200, 10, 1, 1'b1); tick();
      clear_stats = 1'b0;
      chk("t6_clip", {16'd0, clipped_cnt}, 32'd1);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(30 + i, 7, 3, 1'b1); tick();
      end
      drive(0, 0, 0, 1'b0);
      chk("t6_count5", {27'd0, count}, 32'd5);
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      chk("t6_rcount", {27'd0, count}, 32'd0);
      chk("t6_rplot", {31'd0, out_plot}, 32'd0);
      chk("t6_rx", {24'd0, out_x}, 32'd0);
      tick();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         int r;
         r = int'($urandom_range(0, 7));
         if (r == 0)      in_x = 8'($urandom_range(160, 255));
         else if (r == 1) in_x = ($urandom_range(0, 1) != 0) ? 8'd159 : 8'd160;
         else             in_x = 8'($urandom_range(0, 159));
         r = int'($urandom_range(0, 7));
         if (r == 0)      in_y = 7'($urandom_range(120, 127));
         else if (r == 1) in_y = ($urandom_range(0, 1) != 0) ? 7'd119 : 7'd120;
         else             in_y = 7'($urandom_range(0, 119));
         in_colour   = 3'($urandom);
         in_plot     = ($urandom_range(0, 3) != 0);
         if (((c / 150) % 2) != 0) out_ready = ($urandom_range(0, 3) == 0);
         else                      out_ready = ($urandom_range(0, 3) != 0);
         clear_stats = ($urandom_range(0, 63) == 0);
         rst_n       = ($urandom_range(0, 499) != 0);
         tick();
      end
      rst_n = 1'b1; in_plot = 1'b0; clear_stats = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
